// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM state
// encoding and the sizing helper for the chunk counter.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter able to index n chunks; never narrower than one bit
    // so a single-chunk configuration still has a legal counter register.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Purely combinational CHUNK-bit ripple adder. Besides the sum and the
// carry out it exports the carry into the top bit, which the parent
// uses to form signed overflow on the most significant chunk.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o  = carry[CHUNK];
    assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of the chunk ripple chain.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple adder is reused over
// WIDTH/CHUNK cycles, least-significant chunk first, with the inter-chunk
// carry held in a register. Valid/ready handshakes on both sides; a new
// operation is accepted only once the previous result has been consumed.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import adder_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // Operands and accumulator are kept as arrays of chunks so the active
    // chunk is selected directly by the counter.
    state_e                          state_q;
    logic [NCHUNK-1:0][CHUNK-1:0]    a_q;
    logic [NCHUNK-1:0][CHUNK-1:0]    b_q;
    logic [NCHUNK-1:0][CHUNK-1:0]    acc_q;
    logic [NCHUNK-1:0][CHUNK-1:0]    acc_d;
    logic                            carry_q;
    logic [CW-1:0]                   k_q;
    logic [WIDTH-1:0]                sum_q;
    logic                            cout_q;
    logic                            ovf_q;
    logic                            in_ready_q;
    logic                            out_valid_q;

    logic [CHUNK-1:0]                chunk_sum;
    logic                            chunk_cout;
    logic                            chunk_c_msb;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i     (a_q[k_q]),
        .b_i     (b_q[k_q]),
        .cin_i   (carry_q),
        .sum_o   (chunk_sum),
        .cout_o  (chunk_cout),
        .c_msb_o (chunk_c_msb)
    );

    // Accumulator with the current chunk's sum merged in; on the last chunk
    // this is the complete result copied to the output registers.
    always_comb begin
        acc_d      = acc_q;
        acc_d[k_q] = chunk_sum;
    end

    // Control FSM plus all datapath registers. Subtraction is done as
    // a + ~b + ~borrow, so b is inverted and the carry seeded with cin^sub
    // at acceptance. Outputs only change on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        carry_q    <= cin ^ sub;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= chunk_cout;
                    k_q     <= k_q + CW'(1);
                    if (k_q == LAST) begin
                        sum_q       <= acc_d;
                        cout_q      <= chunk_cout;
                        ovf_q       <= chunk_cout ^ chunk_c_msb;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor that reuses one CHUNK-bit ripple adder over WIDTH/CHUNK cycles, least-significant chunk first, with a registered inter-chunk carry. It trades latency for area against the fully unrolled ripple adders. It sits on the datapath behind a valid/ready handshake on both input and output, so it can be dropped between register stages without extra glue.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits added per cycle; CHUNK == WIDTH gives single-chunk operation
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add, borrow-in for subtract
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of the MSB; for subtract, 1 means no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- NCHUNK = WIDTH/CHUNK. Counter width = clog2(NCHUNK), minimum 1.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch a, latch b XOR {WIDTH{sub}}, set carry register to cin XOR sub, clear chunk counter k, then go to RUN.
  - RUN:
    - Each cycle, add chunk k of the latched operands plus the carry register.
    - Write the chunk sum into accumulator bits [k*CHUNK +: CHUNK] and the chunk carry-out into the carry register. Increment k.
    - On the last chunk (k == NCHUNK-1), copy the accumulator (including the last chunk's sum), cout and ovf into the output registers, then go to DONE.
  - DONE:
    - out_valid=1.
    - On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. There is no overlap of operations and no same-cycle re-accept in DONE.
- sum, cout and ovf change only on the completion edge. They hold the last result through IDLE, RUN and DONE. The accumulator is never visible on the outputs.
- ovf uses the carry into the top bit of the final chunk, exported by the chunk sub-module.
- Inputs a, b, cin and sub are sampled only at acceptance. Later changes have no effect.
- Reset, at any time including mid-RUN or mid-DONE:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum, cout, ovf, accumulator, carry register and k all return to 0.
  - The operation in flight is discarded.

## Timing
- Acceptance edge E0 (IDLE, in_valid=1). Chunk i is processed on edge E(i+1). Results and out_valid appear after edge E(NCHUNK).
- Latency from acceptance edge to out_valid high is NCHUNK cycles.
- DONE with out_ready=1 at edge Ed: out_valid=0 and in_ready=1 after Ed. The earliest next acceptance is at edge Ed+1.
- Peak throughput is one operation per NCHUNK+2 cycles.
- While DONE persists with out_ready=0, out_valid and all results stay stable.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- With CHUNK == WIDTH, the block passes through RUN for exactly one cycle, giving 1-cycle latency.

## Structure
- Shared package adder_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - a clog2-based helper for the counter width
- Sub-module chunk_adder, parametrised by CHUNK and purely combinational:
  - A CHUNK-stage ripple of the team's existing one-bit full adder.
  - Outputs: chunk sum, carry-out, and carry into the top bit (c_msb).
- Top level holds the FSM, operand registers, accumulator, carry register, counter and output registers.
- Elaboration-time check: WIDTH % CHUNK == 0 and CHUNK >= 1.

## Test plan
All scenarios use WIDTH=32, CHUNK=8 unless stated otherwise.
- Reset/basic:
  - Stimulus: after reset, all outputs 0 and in_ready=1. Then a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0.
  - Required: out_valid high exactly 4 cycles after acceptance; sum=0x00000000, cout=1, ovf=0.
- Signed overflow and carry-in:
  - Stimulus 1: a=0x7FFFFFFF, b=0, cin=1, sub=0.
  - Required 1: sum=0x80000000, cout=0, ovf=1.
  - Stimulus 2: a=0x00FF00FF, b=0x00010001, cin=0.
  - Required 2: sum=0x01000100, which exercises the inter-chunk carry.
- Subtract:
  - Stimulus 1: a=5, b=7, cin=0, sub=1.
  - Required 1: sum=0xFFFFFFFE, cout=0, ovf=0.
  - Stimulus 2: a=0x80000000, b=1, sub=1.
  - Required 2: sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: result stable, in_ready=0, no new acceptance. After out_ready=1, in_ready=1 the following cycle and the next operation is accepted one edge later.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously after 2 chunks of a=0x12345678 + 0x11111111.
  - Required: state IDLE and outputs 0 immediately; a subsequent 3+4 yields sum=7.
- Reparametrisation:
  - Stimulus 1: WIDTH=16, CHUNK=4, 0xFFFF+0x0001.
  - Required 1: latency 4 cycles, sum=0, cout=1.
  - Stimulus 2: WIDTH=CHUNK=8, 0x7F+0x01.
  - Required 2: latency 1 cycle, sum=0x80, ovf=1.
